branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Registered, handshaked branch resolution stage for the execute pipeline, replacing the purely combinational compare/taken unit. It adds unsigned compares, jump-register, target and link computation, misprediction detection against the fetch prediction, a held redirect handshake toward fetch, and a 2-bit-counter branch history table (BHT) that fetch reads and resolution updates.

## Interface
- `N`, 32, datapath/PC width (≥ 8)
- `BHT_DEPTH`, 64, BHT entries, power of two ≥ 2
- `BHT_INIT`, 2'b01, counter reset value (weakly not-taken)

- `clk` in 1, rising-edge clock
- `rst_n` in 1, reset, asynchronous and active-low
- `flush` in 1, synchronous kill of this stage
- `in_valid` / `in_ready` in / out 1, request handshake
- `in_mode` in 2, 00 off, 01 jump (JAL), 10 compare, 11 jump-register (JALR)
- `in_cmp_type` in 3, 000 EQ, 001 NE, 010 LT, 011 GT, 100 LE, 101 GE (signed), 110 LTU, 111 GEU (unsigned)
- `in_rs1`, `in_rs2`, `in_pc`, `in_imm` in N each, operands, PC, sign-extended immediate
- `in_pred_taken` in 1, `in_pred_target` in N, fetch prediction
- `res_valid`, `res_taken`, `res_mispredict` out 1 each; `res_target`, `res_link` out N each
- `redirect_valid` out 1, `redirect_pc` out N, `redirect_ready` in 1
- `bht_rd_pc` in N, `bht_rd_taken` out 1, fetch-side BHT lookup

## Operation
- Accept = `in_valid && in_ready && !flush`; `in_ready = (state == IDLE)`.
- Taken: mode 00 → 0; 01/11 → 1; 10 → result of `in_cmp_type` (signed for 000–101, unsigned for 110/111).
- Target: mode 01/10 → `pc + imm`; mode 11 → `(rs1 + imm)` with bit 0 cleared; mode 00 → `pc + 4`. Link = `pc + 4`. All adds are modulo 2^N and wrap silently.
- Actual next PC = taken ? target : pc+4. Predicted next PC = pred_taken ? pred_target : pc+4.
- Mispredict = actual ≠ predicted, i.e. (taken ≠ pred_taken) or (taken and target ≠ pred_target).
- FSM: IDLE → REDIRECT on an accept with mispredict. REDIRECT → IDLE on `redirect_valid && redirect_ready`, or on `flush`. In REDIRECT, `redirect_valid=1` and `redirect_pc` is held stable.
- BHT: index = `pc[$clog2(BHT_DEPTH)+1:2]`. On an accept with mode 10, the counter saturates up when taken and down when not taken (00↔11). Other modes do not update it. `bht_rd_taken` = counter MSB, combinational.
- Flush has priority over everything. It blocks same-cycle accept and BHT update, clears `res_valid`, and forces IDLE.

## Timing
- Latency 1: the accept at edge k gives `res_*` valid during cycle k+1. `res_valid` is a one-cycle pulse. `res_*` data holds its value until the next accept.
- Back-to-back accepts sustain 1 per cycle while predictions are correct.
- `redirect_valid` rises in the same cycle as the mispredicting `res_valid`, and `in_ready` drops in that cycle. If `redirect_ready` is already high in that cycle, the unit is back in IDLE on the next cycle.
- BHT write takes effect at the accept edge. A same-cycle read of the same index returns the old value.
- Reset values: `res_*`=0, `redirect_valid`=0, `redirect_pc`=0, state IDLE, all counters = `BHT_INIT`, `in_ready`=1 after reset release.
- Reset asserted mid-redirect drops `redirect_valid` immediately (asynchronously).

## Structure
- Shared package `branch_pkg`: mode enum, cmp_type enum, FSM state enum, 2-bit counter constants (SNT/WNT/WT/ST), and a saturating update function.
- Sub-module `branch_bht`: counter array with async reset, comb read port, single write port. Compare, target and FSM logic stay in the top module.

## Test plan
- EQ compare, rs1=rs2=5, pred_taken=1, pred_target=pc+imm (pc=0x100, imm=0x20) → res_taken=1, target 0x120, no mispredict, redirect_valid stays 0.
- LT vs LTU, rs1=0xFFFFFFFF, rs2=1: LT → taken; LTU → not taken. With pred_taken=1, LTU → mispredict, redirect_pc=0x104 (pc=0x100), and it is held across 3 cycles of redirect_ready=0.
- JALR rs1=0x1001, imm=0x10, pred_target=0x1010 → target 0x1010 (bit 0 cleared), link pc+4, no mispredict. Same case with pred_target=0x2000 → mispredict.
- BHT: three taken compares at pc=0x40 take the counter 01→10→11→11, and bht_rd_taken(0x40)=1. pc=0x140 aliases the same entry when BHT_DEPTH=64. A same-cycle read returns the pre-update value.
- Flush in the accept cycle → no res_valid, no BHT change. Flush during REDIRECT → IDLE next cycle, redirect_valid=0.
- Wrap: pc=0xFFFFFFFC, mode 00 → target/link 0x0. rst_n low mid-REDIRECT → all outputs 0 and the BHT is reinitialised.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution stage.
//   mode_e   : branch operation selector
//   cmp_e    : compare type (signed 000-101, unsigned 110/111)
//   state_e  : resolve/redirect FSM state
//   CTR_*    : 2-bit saturating counter encodings
//   ctr_update: saturating counter step
package branch_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_JAL  = 2'b01,
        MODE_CMP  = 2'b10,
        MODE_JALR = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LT  = 3'b010,
        CMP_GT  = 3'b011,
        CMP_LE  = 3'b100,
        CMP_GE  = 3'b101,
        CMP_LTU = 3'b110,
        CMP_GEU = 3'b111
    } cmp_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Move one step toward the resolved direction, saturating at either end.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: array of 2-bit saturating counters.
//   clk, rst_n         : clock, async active-low reset (all entries -> INIT)
//   wr_en/wr_idx/wr_taken : single update port, applied at the clock edge
//   rd_idx / rd_taken  : combinational lookup, returns counter MSB
module branch_bht
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter logic [1:0]  INIT  = CTR_WNT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic                     wr_taken,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_taken
);

    logic [1:0] ctr_q [DEPTH];

    // Counter array; reads see the pre-update value in the write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) ctr_q[i] <= INIT;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], wr_taken);
        end
    end

    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage with redirect handshake and BHT.
//   in_*      : request (mode, compare type, operands, PC, imm, prediction)
//   res_*     : resolved result, valid one cycle after accept
//   redirect_*: held redirect toward fetch on mispredict
//   bht_rd_*  : fetch-side BHT lookup (combinational)
//   flush     : synchronous kill, highest priority
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter logic [1:0]  BHT_INIT  = 2'b01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [2:0]   in_cmp_type,
    input  logic [N-1:0] in_rs1,
    input  logic [N-1:0] in_rs2,
    input  logic [N-1:0] in_pc,
    input  logic [N-1:0] in_imm,
    input  logic         in_pred_taken,
    input  logic [N-1:0] in_pred_target,
    output logic         res_valid,
    output logic         res_taken,
    output logic         res_mispredict,
    output logic [N-1:0] res_target,
    output logic [N-1:0] res_link,
    output logic         redirect_valid,
    output logic [N-1:0] redirect_pc,
    input  logic         redirect_ready,
    input  logic [N-1:0] bht_rd_pc,
    output logic         bht_rd_taken
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    mode_e  mode;
    cmp_e   cmp;
    state_e state_q, state_d;

    logic         accept;
    logic         eq, lt_s, lt_u;
    logic         taken_c;
    logic [N-1:0] seq_pc, jalr_sum, target_c, actual_pc, pred_pc;
    logic         mispredict_c;
    logic         unused_rd_bits;

    assign mode = mode_e'(in_mode);
    assign cmp  = cmp_e'(in_cmp_type);

    assign in_ready       = (state_q == ST_IDLE);
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign accept         = in_valid && in_ready && !flush;

    assign eq   = (in_rs1 == in_rs2);
    assign lt_s = ($signed(in_rs1) < $signed(in_rs2));
    assign lt_u = (in_rs1 < in_rs2);

    assign seq_pc   = in_pc + N'(4);
    assign jalr_sum = in_rs1 + in_imm;

    // Direction and target resolution.
    always_comb begin
        taken_c  = 1'b0;
        target_c = seq_pc;
        unique case (mode)
            MODE_OFF: begin
                taken_c  = 1'b0;
                target_c = seq_pc;
            end
            MODE_JAL: begin
                taken_c  = 1'b1;
                target_c = in_pc + in_imm;
            end
            MODE_CMP: begin
                target_c = in_pc + in_imm;
                unique case (cmp)
                    CMP_EQ:  taken_c = eq;
                    CMP_NE:  taken_c = !eq;
                    CMP_LT:  taken_c = lt_s;
                    CMP_GT:  taken_c = !lt_s && !eq;
                    CMP_LE:  taken_c = lt_s || eq;
                    CMP_GE:  taken_c = !lt_s;
                    CMP_LTU: taken_c = lt_u;
                    CMP_GEU: taken_c = !lt_u;
                endcase
            end
            MODE_JALR: begin
                taken_c  = 1'b1;
                target_c = {jalr_sum[N-1:1], 1'b0};
            end
        endcase
    end

    assign actual_pc    = taken_c ? target_c : seq_pc;
    assign pred_pc      = in_pred_taken ? in_pred_target : seq_pc;
    assign mispredict_c = (actual_pc != pred_pc);

    // Next-state: hold redirect until fetch takes it; flush always wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (accept && mispredict_c) state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready)         state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Result and redirect registers; data holds until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
            res_target     <= '0;
            res_link       <= '0;
            redirect_pc    <= '0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                res_taken      <= taken_c;
                res_mispredict <= mispredict_c;
                res_target     <= target_c;
                res_link       <= seq_pc;
                if (mispredict_c) redirect_pc <= actual_pc;
            end
        end
    end

    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .INIT  (BHT_INIT)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept && (mode == MODE_CMP)),
        .wr_idx   (in_pc[IDX_W+1:2]),
        .wr_taken (taken_c),
        .rd_idx   (bht_rd_pc[IDX_W+1:2]),
        .rd_taken (bht_rd_taken)
    );

    // Lookup ignores byte offset and PC bits above the index.
    assign unused_rd_bits = ^{bht_rd_pc[N-1:IDX_W+2], bht_rd_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with an expected-result queue.
module tb_branch_resolve_unit;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [2:0]   in_cmp_type;
    logic [N-1:0] in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
    logic         in_pred_taken;
    logic         res_valid, res_taken, res_mispredict;
    logic [N-1:0] res_target, res_link;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         redirect_ready;
    logic [N-1:0] bht_rd_pc;
    logic         bht_rd_taken;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic [31:0] target;
        logic [31:0] link;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    branch_resolve_unit #(.N(N), .BHT_DEPTH(64), .BHT_INIT(2'b01)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mode        (in_mode),
        .in_cmp_type    (in_cmp_type),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .res_target     (res_target),
        .res_link       (res_link),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .bht_rd_pc      (bht_rd_pc),
        .bht_rd_taken   (bht_rd_taken)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] mode, input logic [2:0] ct,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pt, input logic [31:0] ptgt);
        exp_t e;
        logic signed [31:0] a, b;
        logic [31:0] act, prd;
        a = rs1;
        b = rs2;
        e.link   = pc + 32'd4;
        e.taken  = 1'b0;
        e.target = pc + 32'd4;
        case (mode)
            2'b01: begin e.taken = 1'b1; e.target = pc + imm; end
            2'b10: begin
                e.target = pc + imm;
                case (ct)
                    3'd0: e.taken = (a == b);
                    3'd1: e.taken = (a != b);
                    3'd2: e.taken = (a <  b);
                    3'd3: e.taken = (a >  b);
                    3'd4: e.taken = (a <= b);
                    3'd5: e.taken = (a >= b);
                    3'd6: e.taken = (rs1 <  rs2);
                    default: e.taken = (rs1 >= rs2);
                endcase
            end
            2'b11: begin e.taken = 1'b1; e.target = (rs1 + imm) & 32'hFFFF_FFFE; end
            default: ;
        endcase
        act   = e.taken ? e.target : e.link;
        prd   = pt ? ptgt : e.link;
        e.mis = (act != prd);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request; queue its expected result unless flush kills it.
    task automatic drive(input logic [1:0] mode, input logic [2:0] ct,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
        in_mode = mode; in_cmp_type = ct; in_rs1 = rs1; in_rs2 = rs2;
        in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
        in_valid = 1'b1;
        if (!flush) q.push_back(model(mode, ct, rs1, rs2, pc, imm, pt, ptgt));
    endtask

    // Advance one clock, then check res_* against the queue head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("res_valid", 32'(res_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("res_taken",      32'(res_taken),      32'(e.taken));
            chk("res_mispredict", 32'(res_mispredict), 32'(e.mis));
            chk("res_target",     res_target,          e.target);
            chk("res_link",       res_link,            e.link);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] pc, input logic exp);
        bht_rd_pc = pc;
        #1;
        chk(tag, 32'(bht_rd_taken), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; redirect_ready = 1'b0;
        in_mode = '0; in_cmp_type = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0;
        in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0; bht_rd_pc = 32'h40;

        // Reset state
        #11;
        chk("rst_res_valid",  32'(res_valid), 32'd0);
        chk("rst_redirect_v", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_res_target", res_target, 32'd0);
        chk("rst_bht", 32'(bht_rd_taken), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // EQ taken, correctly predicted
        drive(2'b10, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120);
        tick();
        chk("eq_redirect_v", 32'(redirect_valid), 32'd0);

        // Signed LT taken, correctly predicted (back-to-back)
        drive(2'b10, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1, 32'h120);
        tick();
        chk("lt_redirect_v", 32'(redirect_valid), 32'd0);

        // Unsigned LTU not taken, predicted taken -> redirect to pc+4
        drive(2'b10, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1, 32'h120);
        tick();
        chk("ltu_redirect_v", 32'(redirect_valid), 32'd1);
        chk("ltu_redirect_pc", redirect_pc, 32'h104);
        chk("ltu_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_redirect_v", 32'(redirect_valid), 32'd1);
            chk("hold_redirect_pc", redirect_pc, 32'h104);
        end
        redirect_ready = 1'b1;
        tick();
        chk("release_redirect_v", 32'(redirect_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // JALR: bit 0 cleared, correct then wrong target prediction
        drive(2'b11, 3'd0, 32'h1001, 32'd0, 32'h200, 32'h10, 1'b1, 32'h1010);
        tick();
        chk("jalr_redirect_v", 32'(redirect_valid), 32'd0);
        drive(2'b11, 3'd0, 32'h1001, 32'd0, 32'h200, 32'h10, 1'b1, 32'h2000);
        tick();
        chk("jalr_mis_redirect_v", 32'(redirect_valid), 32'd1);
        chk("jalr_mis_redirect_pc", redirect_pc, 32'h1010);
        tick();
        chk("jalr_fast_release", 32'(redirect_valid), 32'd0);
        chk("jalr_in_ready", 32'(in_ready), 32'd1);

        // BHT training at pc 0x40 (aliases with 0x140)
        rd_chk("bht_init", 32'h40, 1'b0);
        drive(2'b10, 3'd0, 32'd7, 32'd7, 32'h40, 32'h8, 1'b1, 32'h48);
        rd_chk("bht_same_cycle", 32'h140, 1'b0);
        tick();
        rd_chk("bht_01_10", 32'h40, 1'b1);
        drive(2'b10, 3'd0, 32'd7, 32'd7, 32'h40, 32'h8, 1'b1, 32'h48);
        tick();
        rd_chk("bht_10_11_alias", 32'h140, 1'b1);
        drive(2'b10, 3'd0, 32'd7, 32'd7, 32'h40, 32'h8, 1'b1, 32'h48);
        tick();
        rd_chk("bht_11_sat", 32'h40, 1'b1);
        drive(2'b10, 3'd1, 32'd7, 32'd7, 32'h40, 32'h8, 1'b0, 32'h0);
        tick();
        rd_chk("bht_11_10", 32'h40, 1'b1);
        drive(2'b10, 3'd1, 32'd7, 32'd7, 32'h40, 32'h8, 1'b0, 32'h0);
        tick();
        rd_chk("bht_10_01", 32'h40, 1'b0);

        // Flush in the accept cycle: no result, no BHT change
        flush = 1'b1;
        drive(2'b10, 3'd0, 32'd7, 32'd7, 32'h40, 32'h8, 1'b1, 32'h48);
        tick();
        flush = 1'b0;
        rd_chk("flush_bht", 32'h40, 1'b0);

        // Flush during REDIRECT
        redirect_ready = 1'b0;
        drive(2'b01, 3'd0, 32'd0, 32'd0, 32'h300, 32'h40, 1'b0, 32'h0);
        tick();
        chk("jal_redirect_v", 32'(redirect_valid), 32'd1);
        chk("jal_redirect_pc", redirect_pc, 32'h340);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_redirect_v", 32'(redirect_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);

        // Wrap of pc+4
        drive(2'b00, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h123, 1'b0, 32'h0);
        tick();

        // Reset in the middle of a redirect
        drive(2'b10, 3'd0, 32'd3, 32'd3, 32'h40, 32'h8, 1'b0, 32'h0);
        tick();
        chk("pre_rst_redirect_v", 32'(redirect_valid), 32'd1);
        rd_chk("pre_rst_bht", 32'h40, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_redirect_v", 32'(redirect_valid), 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_res_taken", 32'(res_taken), 32'd0);
        chk("arst_res_mis", 32'(res_mispredict), 32'd0);
        chk("arst_res_target", res_target, 32'd0);
        chk("arst_res_link", res_link, 32'd0);
        chk("arst_bht", 32'(bht_rd_taken), 32'd0);
        q.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
